mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch stage (I) and the data-memory stage (D) of the RISC-V pipeline.
- Serialises requests, with one outstanding transaction at a time.
- Data has priority over fetch, bounded by an anti-starvation streak limit.
- Generates per-requester done, error and stall signals for pipeline hazard control.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the port arbiter and the
// single-port unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_done;
  logic                  if_err;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_done;
  logic                  d_err;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_done, if_err, if_rdata, if_stall, d_done, d_err, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_done, if_err, if_rdata, if_stall, d_done, d_err, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-port memory.
// Data wins arbitration unless it has starved a waiting fetch MAX_D_STREAK times.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_D_STREAK);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STK_W-1:0]    streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_done_s, if_err_s, d_done_s, d_err_s;

  // State, counters and the latched memory command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  // Arbitration, completion and timeout decisions
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_done_s   = 1'b0;
    if_err_s    = 1'b0;
    d_done_s    = 1'b0;
    d_err_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (bus.d_req && (!bus.if_req || (streak_q < STK_MAX))) begin
          state_d     = ST_SERVE_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_be;
          if (bus.if_req) begin
            streak_d = (streak_q < STK_MAX) ? streak_q + 1'b1 : streak_q;
          end else begin
            streak_d = '0;
          end
        end else if (bus.if_req) begin
          state_d     = ST_SERVE_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          streak_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        // An ack in the last allowed cycle still counts as a completion.
        if (bus.mem_ack) begin
          if_done_s = (state_q == ST_SERVE_I);
          d_done_s  = (state_q == ST_SERVE_D);
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          tmo_d     = '0;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          if_err_s  = (state_q == ST_SERVE_I);
          d_err_s   = (state_q == ST_SERVE_D);
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        tmo_d     = '0;
      end
    endcase
  end

  assign bus.if_done   = if_done_s;
  assign bus.if_err    = if_err_s;
  assign bus.d_done    = d_done_s;
  assign bus.d_err     = d_err_s;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.if_stall  = reset & bus.if_req & ~if_done_s;
  assign bus.d_stall   = reset & bus.d_req & ~d_done_s;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the arbiter kept in this bench.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT      = 8;
  localparam int OWN_NONE     = 0;
  localparam int OWN_I        = 1;
  localparam int OWN_D        = 2;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks;
  int n_fail;

  // reference model: who owns the memory, how long, and the command it was given
  int                owner_m;
  int                age_m;
  int                streak_m;
  logic              lat_we_m;
  logic [ADDR_W-1:0] lat_addr_m;
  logic [DATA_W-1:0] lat_wdata_m;
  logic [BE_W-1:0]   lat_be_m;
  int                ack_mode;
  logic              fin_i, fin_d;

  logic              obs_mem_req, obs_mem_we, obs_if_done, obs_d_done, obs_d_err;
  logic [ADDR_W-1:0] obs_mem_addr;
  logic [DATA_W-1:0] obs_if_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner_m  = OWN_NONE;
    age_m    = 0;
    streak_m = 0;
  endtask

  // one clock: check outputs at negedge, advance the model at posedge, drive memory
  task automatic step();
    logic tmo_hit, e_idone, e_ierr, e_ddone, e_derr;
    @(negedge clk);
    tmo_hit = (TIMEOUT != 0) && (age_m == TIMEOUT - 1);
    e_idone = (owner_m == OWN_I) && bus.mem_ack;
    e_ierr  = (owner_m == OWN_I) && !bus.mem_ack && tmo_hit;
    e_ddone = (owner_m == OWN_D) && bus.mem_ack;
    e_derr  = (owner_m == OWN_D) && !bus.mem_ack && tmo_hit;
    fin_i = e_idone || e_ierr;
    fin_d = e_ddone || e_derr;
    obs_mem_req  = bus.mem_req;
    obs_mem_we   = bus.mem_we;
    obs_mem_addr = bus.mem_addr;
    obs_if_done  = bus.if_done;
    obs_if_rdata = bus.if_rdata;
    obs_d_done   = bus.d_done;
    obs_d_err    = bus.d_err;
    check_eq("mem_req", 32'(bus.mem_req), 32'(owner_m != OWN_NONE));
    if (owner_m != OWN_NONE) begin
      check_eq("mem_we", 32'(bus.mem_we), 32'(lat_we_m));
      check_eq("mem_addr", bus.mem_addr, lat_addr_m);
      check_eq("mem_wdata", bus.mem_wdata, lat_wdata_m);
      check_eq("mem_be", 32'(bus.mem_be), 32'(lat_be_m));
    end
    check_eq("if_done", 32'(bus.if_done), 32'(e_idone));
    check_eq("if_err", 32'(bus.if_err), 32'(e_ierr));
    check_eq("d_done", 32'(bus.d_done), 32'(e_ddone));
    check_eq("d_err", 32'(bus.d_err), 32'(e_derr));
    if (e_idone) check_eq("if_rdata", bus.if_rdata, bus.mem_rdata);
    if (e_ddone) check_eq("d_rdata", bus.d_rdata, bus.mem_rdata);
    check_eq("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !e_idone));
    check_eq("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !e_ddone));
    @(posedge clk);
    if (owner_m != OWN_NONE) begin
      if (bus.mem_ack || tmo_hit) begin
        owner_m = OWN_NONE;
        age_m   = 0;
      end else begin
        age_m++;
      end
    end else if (bus.d_req && (!bus.if_req || streak_m < MAX_D_STREAK)) begin
      owner_m     = OWN_D;
      lat_we_m    = bus.d_we;
      lat_addr_m  = bus.d_addr;
      lat_wdata_m = bus.d_wdata;
      lat_be_m    = bus.d_be;
      streak_m    = bus.if_req ? ((streak_m < MAX_D_STREAK) ? streak_m + 1 : streak_m) : 0;
    end else if (bus.if_req) begin
      owner_m     = OWN_I;
      lat_we_m    = 1'b0;
      lat_addr_m  = bus.if_addr;
      lat_wdata_m = '0;
      lat_be_m    = '0;
      streak_m    = 0;
    end
    #1;
    case (ack_mode)
      0:       bus.mem_ack = 1'b0;
      1:       bus.mem_ack = (owner_m != OWN_NONE);
      default: bus.mem_ack = (owner_m != OWN_NONE) && ($urandom_range(0, 99) < 30);
    endcase
    bus.mem_rdata = $urandom;
  endtask

  task automatic new_d(input logic we);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = $urandom;
    bus.d_wdata = $urandom;
    bus.d_be    = 4'($urandom);
  endtask

  // requesters: hold until finished, then maybe issue again; pending fields may wander
  task automatic rand_drive();
    if (!bus.if_req || fin_i) begin
      bus.if_req  = ($urandom_range(0, 99) < 45);
      bus.if_addr = $urandom;
    end else if ($urandom_range(0, 7) == 0) begin
      bus.if_addr = $urandom;
    end
    if (!bus.d_req || fin_d) begin
      new_d(1'($urandom_range(0, 1)));
      bus.d_req = ($urandom_range(0, 99) < 55);
    end else if ($urandom_range(0, 7) == 0) begin
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
  endtask

  initial begin
    int d_cnt, rounds, cnt_req;
    logic saw_done, saw_err;
    n_checks = 0;
    n_fail   = 0;
    ack_mode = 1;
    model_reset();
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check_eq("rst_dones", 32'({bus.if_done, bus.if_err, bus.d_done, bus.d_err}), 32'd0);
    check_eq("rst_stalls", 32'({bus.if_stall, bus.d_stall}), 32'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    reset = 1'b1;

    // single fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    step();
    bus.mem_rdata = 32'hDEADBEEF;
    step();
    check_eq("fetch_done", 32'(obs_if_done), 32'd1);
    check_eq("fetch_addr", obs_mem_addr, 32'h100);
    check_eq("fetch_rdata", obs_if_rdata, 32'hDEADBEEF);
    bus.if_req = 1'b0;
    step();

    // simultaneous requests: store first, fetch after one idle cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_be = 4'hF;
    step();
    step();
    check_eq("simul_d_first", 32'({obs_d_done, obs_mem_we, obs_if_done}), 32'b110);
    bus.d_req = 1'b0;
    step();
    check_eq("simul_idle_gap", 32'(obs_mem_req), 32'd0);
    step();
    check_eq("simul_i_second", 32'(obs_if_done), 32'd1);
    check_eq("simul_i_addr", obs_mem_addr, 32'h300);
    bus.if_req = 1'b0;

    // starvation guard: D always pending, I waiting
    bus.if_req = 1'b1; bus.if_addr = $urandom;
    new_d(1'b0);
    d_cnt = 0; rounds = 0;
    for (int i = 0; i < 60 && rounds < 2; i++) begin
      step();
      if (obs_d_done) begin
        d_cnt++;
        new_d(1'($urandom_range(0, 1)));
      end
      if (obs_if_done) begin
        check_eq("starve_d_grants", 32'(d_cnt), 32'(MAX_D_STREAK));
        d_cnt = 0;
        rounds++;
        bus.if_addr = $urandom;
      end
    end
    check_eq("starve_rounds", 32'(rounds), 32'd2);
    bus.if_req = 1'b0;

    // timeout with memory silent
    ack_mode = 0;
    new_d(1'b0);
    cnt_req = 0; saw_done = 1'b0; saw_err = 1'b0;
    for (int i = 0; i < 30 && !saw_err; i++) begin
      step();
      if (obs_mem_req) cnt_req++;
      if (obs_d_done) saw_done = 1'b1;
      if (obs_d_err) saw_err = 1'b1;
    end
    check_eq("tmo_err_seen", 32'(saw_err), 32'd1);
    check_eq("tmo_cycles", 32'(cnt_req), 32'(TIMEOUT));
    check_eq("tmo_no_done", 32'(saw_done), 32'd0);
    bus.d_req = 1'b0;
    step();
    check_eq("tmo_req_drop", 32'(obs_mem_req), 32'd0);

    // ack in the last allowed cycle wins over the timeout
    new_d(1'b1);
    step();
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    bus.mem_ack = 1'b1;
    step();
    check_eq("late_ack_done_err", 32'({obs_d_done, obs_d_err}), 32'b10);
    bus.d_req = 1'b0;
    step();

    // input hold while serving D
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400; bus.d_wdata = 32'hA5A5A5A5; bus.d_be = 4'h3;
    step();
    bus.d_addr = 32'h404; bus.d_wdata = 32'h0;
    step();
    check_eq("hold_addr", obs_mem_addr, 32'h400);
    bus.mem_ack = 1'b1;
    step();
    check_eq("hold_addr_done", obs_mem_addr, 32'h400);
    check_eq("hold_done", 32'(obs_d_done), 32'd1);
    bus.d_req = 1'b0;
    step();

    // reset in the middle of a fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("midrst_no_fin", 32'({bus.if_done, bus.if_err}), 32'd0);
    model_reset();
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h600; bus.d_wdata = 32'h600D600D; bus.d_be = 4'hC;
    @(negedge clk);
    check_eq("midrst_quiet", 32'({bus.if_done, bus.if_err, bus.d_done, bus.d_err, bus.mem_req}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ack_mode = 1;
    bus.mem_ack = 1'b0;
    step();
    step();
    check_eq("midrst_d_served", 32'(obs_d_done), 32'd1);
    bus.d_req = 1'b0;
    step();

    // randomized traffic
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_drive();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
